// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants and helpers for the register file and its
// write-port forwarding logic.
package regfile_scoreboard_pkg;

    localparam int XLEN_DEF = 64;
    localparam int NREG_DEF = 32;
    localparam int REG_ZERO = 0;
    localparam int MAX_WR   = 32;

    function automatic int addr_w(input int nreg);
        return $clog2(nreg);
    endfunction

    // Highest set request index; callers check for any hit separately.
    function automatic int prio_sel(input logic [MAX_WR-1:0] req);
        int idx;
        idx = 0;
        for (int j = 0; j < MAX_WR; j++) begin
            if (req[j]) idx = j;
        end
        return idx;
    endfunction

endpackage

// File: rtl/regfile_scoreboard_write_select.sv
// Resolves the winning write port for one register address;
// a higher port index has priority.
module rf_write_select
    import regfile_scoreboard_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NWR  = 2,
    parameter int AW   = 5
) (
    input  logic [AW-1:0]       addr_i,
    input  logic [NWR-1:0]      wr_en_i,
    input  logic [NWR*AW-1:0]   wr_addr_i,
    input  logic [NWR*XLEN-1:0] wr_data_i,
    output logic                hit_o,
    output logic [XLEN-1:0]     data_o
);

    logic [MAX_WR-1:0] req;
    int                win;

    always_comb begin
        req = '0;
        for (int j = 0; j < NWR; j++) begin
            req[j] = wr_en_i[j]
                   && (wr_addr_i[j*AW +: AW] == addr_i)
                   && (addr_i != AW'(REG_ZERO));
        end
        win    = prio_sel(req);
        hit_o  = |req;
        data_o = wr_data_i[win*XLEN +: XLEN];
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port integer register file with write bypass and a
// per-register pending scoreboard for decode hazard checks.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int  XLEN   = XLEN_DEF,
    parameter int  NREG   = NREG_DEF,
    parameter int  NRD    = 2,
    parameter int  NWR    = 2,
    parameter int  BYPASS = 1,
    localparam int AW     = addr_w(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    output logic                iss_ok,
    output logic [NREG-1:0]     busy_vec
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] pend_q, pend_d;
    logic            upd_hit  [NREG];
    logic [XLEN-1:0] upd_data [NREG];

    for (genvar r = 0; r < NREG; r++) begin : g_upd
        rf_write_select #(.XLEN(XLEN), .NWR(NWR), .AW(AW)) u_sel (
            .addr_i    (AW'(r)),
            .wr_en_i   (wr_en),
            .wr_addr_i (wr_addr),
            .wr_data_i (wr_data),
            .hit_o     (upd_hit[r]),
            .data_o    (upd_data[r])
        );
    end

    assign iss_ok = (iss_addr == AW'(REG_ZERO))
                  || !pend_q[iss_addr]
                  || ((BYPASS != 0) && upd_hit[iss_addr]);

    // Issue is applied after write clears so a new producer wins.
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        for (int r = 0; r < NREG; r++) begin
            if (upd_hit[r]) begin
                regs_d[r] = upd_data[r];
                pend_d[r] = 1'b0;
            end
        end
        if (iss_en && iss_ok && (iss_addr != AW'(REG_ZERO))) begin
            pend_d[iss_addr] = 1'b1;
        end
        regs_d[REG_ZERO] = '0;
        pend_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
            pend_q <= '0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
        end
    end

    assign busy_vec = pend_q;

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   a;
        logic            b_hit;
        logic [XLEN-1:0] b_data;
        logic [XLEN-1:0] rdd;
        logic            rdb;

        assign a = rd_addr[i*AW +: AW];

        rf_write_select #(.XLEN(XLEN), .NWR(NWR), .AW(AW)) u_byp (
            .addr_i    (a),
            .wr_en_i   (wr_en),
            .wr_addr_i (wr_addr),
            .wr_data_i (wr_data),
            .hit_o     (b_hit),
            .data_o    (b_data)
        );

        always_comb begin
            rdd = regs_q[a];
            rdb = pend_q[a];
            if (a == AW'(REG_ZERO)) begin
                rdd = '0;
                rdb = 1'b0;
            end else if ((BYPASS != 0) && b_hit) begin
                rdd = b_data;
                rdb = 1'b0;
            end
        end

        assign rd_data[i*XLEN +: XLEN] = rdd;
        assign rd_busy[i]              = rdb;
    end

endmodule
